// File: rtl/id_operand_stage_if.sv
// Bus between the decoder, the operand stage and EX. The stage connects through
// the slave modport; the upstream/downstream environment connects through master.
interface id_operand_stage_if #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 5
);
    logic                 i_valid;
    logic                 o_ready;
    logic [ADDR_W-1:0]    i_pc;
    logic [REG_IDX_W-1:0] i_rs1;
    logic [REG_IDX_W-1:0] i_rs2;
    logic                 i_rs1_en;
    logic                 i_rs2_en;
    logic [REG_IDX_W-1:0] i_rd;
    logic                 i_rd_en;
    logic                 i_is_load;

    logic                 i_exm_wr_en;
    logic [REG_IDX_W-1:0] i_exm_rd;
    logic [WORD_W-1:0]    i_exm_data;
    logic                 i_exm_is_load;

    logic                 i_wb_wr_en;
    logic [REG_IDX_W-1:0] i_wb_rd;
    logic [WORD_W-1:0]    i_wb_data;

    logic                 o_valid;
    logic                 i_ex_ready;
    logic [ADDR_W-1:0]    o_pc;
    logic [WORD_W-1:0]    o_rs1_data;
    logic [WORD_W-1:0]    o_rs2_data;
    logic [REG_IDX_W-1:0] o_rd;
    logic                 o_rd_en;
    logic                 o_is_load;

    modport slave (
        input  i_valid, i_pc, i_rs1, i_rs2, i_rs1_en, i_rs2_en, i_rd, i_rd_en, i_is_load,
        input  i_exm_wr_en, i_exm_rd, i_exm_data, i_exm_is_load,
        input  i_wb_wr_en, i_wb_rd, i_wb_data,
        input  i_ex_ready,
        output o_ready, o_valid, o_pc, o_rs1_data, o_rs2_data, o_rd, o_rd_en, o_is_load
    );

    modport master (
        output i_valid, i_pc, i_rs1, i_rs2, i_rs1_en, i_rs2_en, i_rd, i_rd_en, i_is_load,
        output i_exm_wr_en, i_exm_rd, i_exm_data, i_exm_is_load,
        output i_wb_wr_en, i_wb_rd, i_wb_data,
        output i_ex_ready,
        input  o_ready, o_valid, o_pc, o_rs1_data, o_rs2_data, o_rd, o_rd_en, o_is_load
    );
endinterface

// File: rtl/id_operand_stage.sv
// Decode/operand stage: register file, operand forwarding, load-use interlock and
// the ID/EX pipeline register with a valid/ready handshake towards EX.
module id_operand_stage #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               flush,
    id_operand_stage_if.slave  bus
);
    localparam int NREGS = 1 << REG_IDX_W;

    logic [WORD_W-1:0]    rf [NREGS];

    logic                 valid_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [WORD_W-1:0]    rs1_data_q;
    logic [WORD_W-1:0]    rs2_data_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 rd_en_q;
    logic                 is_load_q;

    logic [WORD_W-1:0]    rs1_val;
    logic [WORD_W-1:0]    rs2_val;
    logic                 hazard;
    logic                 adv;
    logic                 take;

    // Forwarding priority: x0, EX/MEM (non-load), WB write-through, register file.
    function automatic logic [WORD_W-1:0] resolve(
        input logic [REG_IDX_W-1:0] idx,
        input logic [WORD_W-1:0]    rf_val,
        input logic                 exm_fwd,
        input logic [REG_IDX_W-1:0] exm_rd,
        input logic [WORD_W-1:0]    exm_data,
        input logic                 wb_en,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [WORD_W-1:0]    wb_data
    );
        logic [WORD_W-1:0] val;
        if (idx == '0)
            val = '0;
        else if (exm_fwd && exm_rd == idx)
            val = exm_data;
        else if (wb_en && wb_rd == idx)
            val = wb_data;
        else
            val = rf_val;
        return val;
    endfunction

    // A source is blocked while its producer is a load still in ID/EX or EX/MEM.
    function automatic logic load_use(
        input logic                 en,
        input logic [REG_IDX_W-1:0] idx,
        input logic                 idex_load,
        input logic [REG_IDX_W-1:0] idex_rd,
        input logic                 exm_load,
        input logic [REG_IDX_W-1:0] exm_rd
    );
        return en && (idx != '0) &&
               ((idex_load && idex_rd == idx) || (exm_load && exm_rd == idx));
    endfunction

    always_comb begin
        rs1_val = resolve(bus.i_rs1, rf[bus.i_rs1],
                          bus.i_exm_wr_en && !bus.i_exm_is_load, bus.i_exm_rd, bus.i_exm_data,
                          bus.i_wb_wr_en, bus.i_wb_rd, bus.i_wb_data);
        rs2_val = resolve(bus.i_rs2, rf[bus.i_rs2],
                          bus.i_exm_wr_en && !bus.i_exm_is_load, bus.i_exm_rd, bus.i_exm_data,
                          bus.i_wb_wr_en, bus.i_wb_rd, bus.i_wb_data);
    end

    always_comb begin
        hazard = bus.i_valid &&
                 (load_use(bus.i_rs1_en, bus.i_rs1,
                           valid_q && rd_en_q && is_load_q, rd_q,
                           bus.i_exm_wr_en && bus.i_exm_is_load, bus.i_exm_rd) ||
                  load_use(bus.i_rs2_en, bus.i_rs2,
                           valid_q && rd_en_q && is_load_q, rd_q,
                           bus.i_exm_wr_en && bus.i_exm_is_load, bus.i_exm_rd));
        adv  = !valid_q || bus.i_ex_ready;
        take = bus.i_valid && !hazard;
    end

    assign bus.o_ready = adv && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (bus.i_wb_wr_en && bus.i_wb_rd != '0) begin
            rf[bus.i_wb_rd] <= bus.i_wb_data;
        end
    end

    // Flush only kills the valid bit; the payload holds like a bubble.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            rd_en_q    <= 1'b0;
            is_load_q  <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
        end else if (adv) begin
            valid_q <= take;
            if (take) begin
                pc_q       <= bus.i_pc;
                rs1_data_q <= rs1_val;
                rs2_data_q <= rs2_val;
                rd_q       <= bus.i_rd;
                rd_en_q    <= bus.i_rd_en;
                is_load_q  <= bus.i_is_load;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_pc       = pc_q;
    assign bus.o_rs1_data = rs1_data_q;
    assign bus.o_rs2_data = rs2_data_q;
    assign bus.o_rd       = rd_q;
    assign bus.o_rd_en    = rd_en_q;
    assign bus.o_is_load  = is_load_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios then randomized traffic, all
// compared against a cycle-level reference model of the stage's rules.
module tb_id_operand_stage;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int NREGS     = 32;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    id_operand_stage_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W)) bus ();

    id_operand_stage #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .flush   (flush),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rf [NREGS];
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;
    logic [4:0]  m_rd = '0;
    logic        m_rd_en = 1'b0;
    logic        m_is_load = 1'b0;
    logic        seen_ready;

    function automatic logic [31:0] ref_operand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.i_exm_wr_en && !bus.i_exm_is_load && bus.i_exm_rd == idx) return bus.i_exm_data;
        if (bus.i_wb_wr_en && bus.i_wb_rd == idx) return bus.i_wb_data;
        return m_rf[idx];
    endfunction

    // True while a load targeting idx has not yet reached the WB port.
    function automatic logic load_pending(input logic [4:0] idx);
        return (m_valid && m_is_load && m_rd_en && m_rd == idx) ||
               (bus.i_exm_wr_en && bus.i_exm_is_load && bus.i_exm_rd == idx);
    endfunction

    function automatic logic ref_hazard();
        if (!bus.i_valid) return 1'b0;
        return (bus.i_rs1_en && bus.i_rs1 != 5'd0 && load_pending(bus.i_rs1)) ||
               (bus.i_rs2_en && bus.i_rs2 != 5'd0 && load_pending(bus.i_rs2));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check o_ready against the model, advance model, check registered outputs.
    task automatic tick();
        logic haz, adv;
        logic [31:0] op1, op2;
        #1;
        haz = ref_hazard();
        adv = !m_valid || bus.i_ex_ready;
        seen_ready = bus.o_ready;
        if (aresetn) check("o_ready", {63'd0, bus.o_ready}, {63'd0, adv && !haz && !flush});
        op1 = ref_operand(bus.i_rs1);
        op2 = ref_operand(bus.i_rs2);
        @(posedge clk);
        if (!aresetn) begin
            for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
            m_valid = 0; m_pc = '0; m_op1 = '0; m_op2 = '0;
            m_rd = '0; m_rd_en = 0; m_is_load = 0;
        end else begin
            if (bus.i_wb_wr_en && bus.i_wb_rd != 5'd0) m_rf[bus.i_wb_rd] = bus.i_wb_data;
            if (flush) m_valid = 0;
            else if (adv) begin
                m_valid = bus.i_valid && !haz;
                if (bus.i_valid && !haz) begin
                    m_pc = bus.i_pc; m_op1 = op1; m_op2 = op2;
                    m_rd = bus.i_rd; m_rd_en = bus.i_rd_en; m_is_load = bus.i_is_load;
                end
            end
        end
        #1;
        check("o_valid",    {63'd0, bus.o_valid},    {63'd0, m_valid});
        check("o_pc",       {32'd0, bus.o_pc},       {32'd0, m_pc});
        check("o_rs1_data", {32'd0, bus.o_rs1_data}, {32'd0, m_op1});
        check("o_rs2_data", {32'd0, bus.o_rs2_data}, {32'd0, m_op2});
        check("o_rd",       {59'd0, bus.o_rd},       {59'd0, m_rd});
        check("o_rd_en",    {63'd0, bus.o_rd_en},    {63'd0, m_rd_en});
        check("o_is_load",  {63'd0, bus.o_is_load},  {63'd0, m_is_load});
    endtask

    task automatic idle();
        bus.i_valid = 0; bus.i_pc = $urandom;
        bus.i_rs1 = 5'($urandom); bus.i_rs2 = 5'($urandom);
        bus.i_rs1_en = 0; bus.i_rs2_en = 0;
        bus.i_rd = 5'($urandom); bus.i_rd_en = 0; bus.i_is_load = 0;
        bus.i_exm_wr_en = 0; bus.i_exm_rd = 5'($urandom); bus.i_exm_data = $urandom;
        bus.i_exm_is_load = 0;
        bus.i_wb_wr_en = 0; bus.i_wb_rd = 5'($urandom); bus.i_wb_data = $urandom;
        bus.i_ex_ready = 1; flush = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic rs1_en,
                         input logic [4:0] rs2, input logic rs2_en,
                         input logic [4:0] rd, input logic rd_en, input logic is_load);
        bus.i_valid = 1; bus.i_pc = pc;
        bus.i_rs1 = rs1; bus.i_rs1_en = rs1_en; bus.i_rs2 = rs2; bus.i_rs2_en = rs2_en;
        bus.i_rd = rd; bus.i_rd_en = rd_en; bus.i_is_load = is_load;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
        idle();

        // Reset, scribble over the register file, reset again, then read it all back.
        aresetn = 0;
        tick(); tick();
        check("reset_o_valid", {63'd0, bus.o_valid}, 64'd0);
        aresetn = 1;
        for (int i = 1; i < NREGS; i++) begin
            idle();
            bus.i_wb_wr_en = 1; bus.i_wb_rd = 5'(i); bus.i_wb_data = $urandom | 32'h1;
            tick();
        end
        idle();
        aresetn = 0;
        tick(); tick();
        aresetn = 1;
        for (int i = 0; i < NREGS; i++) begin
            idle();
            issue(32'h1000 + 32'(i), 5'(i), 1, 5'(NREGS - 1 - i), 1, 5'd1, 0, 0);
            tick();
            check("reset_rf_rs1", {32'd0, bus.o_rs1_data}, 64'd0);
        end

        // Write-through of a same-cycle WB write.
        idle();
        issue(32'h2000, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
        bus.i_wb_wr_en = 1; bus.i_wb_rd = 5'd5; bus.i_wb_data = 32'hDEAD_BEEF;
        tick();
        check("wb_write_through", {32'd0, bus.o_rs1_data}, 64'hDEAD_BEEF);

        // Forwarding priority: EX/MEM over WB over RF, and x0 over everything.
        idle();
        bus.i_wb_wr_en = 1; bus.i_wb_rd = 5'd7; bus.i_wb_data = 32'h33;
        tick();
        idle();
        issue(32'h2004, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0);
        bus.i_exm_wr_en = 1; bus.i_exm_rd = 5'd7; bus.i_exm_data = 32'h11;
        bus.i_wb_wr_en = 1; bus.i_wb_rd = 5'd7; bus.i_wb_data = 32'h22;
        tick();
        check("fwd_prio_rs1", {32'd0, bus.o_rs1_data}, 64'h11);
        check("fwd_prio_rs2", {32'd0, bus.o_rs2_data}, 64'h11);
        issue(32'h2008, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0);
        bus.i_exm_rd = 5'd0; bus.i_wb_rd = 5'd0;
        tick();
        check("fwd_x0_rs1", {32'd0, bus.o_rs1_data}, 64'd0);
        check("fwd_x0_rs2", {32'd0, bus.o_rs2_data}, 64'd0);

        // Load-use: two bubbles, then the WB-forwarded load data.
        idle();
        issue(32'h3000, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        tick();
        idle();
        issue(32'h3004, 5'd3, 1, 5'd0, 0, 5'd10, 1, 0);
        tick();
        check("lu_bubble1_ready", {63'd0, seen_ready}, 64'd0);
        check("lu_bubble1_valid", {63'd0, bus.o_valid}, 64'd0);
        bus.i_exm_wr_en = 1; bus.i_exm_rd = 5'd3; bus.i_exm_is_load = 1;
        tick();
        check("lu_bubble2_ready", {63'd0, seen_ready}, 64'd0);
        check("lu_bubble2_valid", {63'd0, bus.o_valid}, 64'd0);
        bus.i_exm_wr_en = 0; bus.i_exm_is_load = 0;
        bus.i_wb_wr_en = 1; bus.i_wb_rd = 5'd3; bus.i_wb_data = 32'hCAFE_0003;
        tick();
        check("lu_accept_ready", {63'd0, seen_ready}, 64'd1);
        check("lu_operand", {32'd0, bus.o_rs1_data}, 64'hCAFE_0003);

        // Backpressure: EX stalls for three cycles, then releases.
        idle();
        issue(32'h100, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0);
        tick();
        bus.i_ex_ready = 0;
        issue(32'h200, 5'd4, 1, 5'd5, 1, 5'd11, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ready", {63'd0, seen_ready}, 64'd0);
            check("bp_pc_hold", {32'd0, bus.o_pc}, 64'h100);
        end
        bus.i_ex_ready = 1;
        tick();
        check("bp_release_pc", {32'd0, bus.o_pc}, 64'h200);

        // Flush while the next instruction is interlocked behind a load.
        idle();
        issue(32'h400, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
        tick();
        idle();
        bus.i_ex_ready = 0;
        issue(32'h404, 5'd4, 1, 5'd0, 0, 5'd12, 1, 0);
        flush = 1;
        tick();
        check("flush_ready", {63'd0, seen_ready}, 64'd0);
        check("flush_valid", {63'd0, bus.o_valid}, 64'd0);
        flush = 0; bus.i_ex_ready = 1;
        tick();
        check("post_flush_ready", {63'd0, seen_ready}, 64'd1);
        check("post_flush_pc", {32'd0, bus.o_pc}, 64'h404);

        // Randomized traffic over a small index range to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            aresetn          = ($urandom_range(0, 99) >= 2);
            flush            = ($urandom_range(0, 99) < 5);
            bus.i_ex_ready   = ($urandom_range(0, 99) < 75);
            bus.i_valid      = ($urandom_range(0, 99) < 70);
            bus.i_pc         = $urandom;
            bus.i_rs1        = 5'($urandom_range(0, 7));
            bus.i_rs2        = 5'($urandom_range(0, 7));
            bus.i_rs1_en     = 1'($urandom_range(0, 1));
            bus.i_rs2_en     = 1'($urandom_range(0, 1));
            bus.i_rd         = 5'($urandom_range(0, 7));
            bus.i_rd_en      = 1'($urandom_range(0, 1));
            bus.i_is_load    = ($urandom_range(0, 99) < 30);
            bus.i_exm_wr_en  = 1'($urandom_range(0, 1));
            bus.i_exm_rd     = 5'($urandom_range(0, 7));
            bus.i_exm_data   = $urandom;
            bus.i_exm_is_load = ($urandom_range(0, 99) < 30);
            bus.i_wb_wr_en   = 1'($urandom_range(0, 1));
            bus.i_wb_rd      = 5'($urandom_range(0, 7));
            bus.i_wb_data    = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised decode/operand stage: register file plus operand forwarding, load-use hazard interlock, and an ID/EX pipeline register with valid/ready handshake.
- Accepts pre-extracted register fields from the decoder; delivers resolved operands to the EX stage.
- Replaces the fixed-width, stall-only decode stage: forwarding and the interlock are internal, and backpressure is handled by handshake.

Parameters:
- WORD_W, 32, data word width
- ADDR_W, 32, PC width
- REG_IDX_W, 5, register index width; register file has 2^REG_IDX_W entries, index 0 hardwired zero

Ports:
- clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- flush  in  1  synchronous kill of the ID/EX register contents
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage accepts upstream instruction this cycle
- i_pc  in  ADDR_W  instruction PC
- i_rs1, i_rs2  in  REG_IDX_W  source indices
- i_rs1_en, i_rs2_en  in  1  source used
- i_rd  in  REG_IDX_W  destination index
- i_rd_en  in  1  destination written
- i_is_load  in  1  instruction is a load
- i_exm_wr_en, i_exm_rd, i_exm_data, i_exm_is_load  in  1/REG_IDX_W/WORD_W/1  EX/MEM-register producer
- i_wb_wr_en, i_wb_rd, i_wb_data  in  1/REG_IDX_W/WORD_W  write-back port; writes the register file
- o_valid  out  1  ID/EX register valid
- i_ex_ready  in  1  EX accepts ID/EX contents
- o_pc  out  ADDR_W  registered PC
- o_rs1_data, o_rs2_data  out  WORD_W  registered resolved operands
- o_rd, o_rd_en, o_is_load  out  REG_IDX_W/1/1  registered destination info

Behaviour:
- Reset (aresetn=0 at posedge): every register-file entry and every registered output is 0. o_ready is combinational and may be 1 during reset; nothing is captured while reset is asserted.
- Register file write: at posedge when i_wb_wr_en=1 and i_wb_rd!=0. Writes to index 0 are ignored. Reads are combinational.
- Operand resolution, per source, highest priority first:
  - index 0 gives 0;
  - EX/MEM match (i_exm_wr_en && i_exm_rd==rs, not load) gives i_exm_data;
  - WB match gives i_wb_data (same-cycle write-through);
  - otherwise the register-file value.
- Hazard (combinational), only when i_valid=1. It is raised if an enabled source rs!=0 matches either:
  - (o_valid && o_rd_en && o_is_load && o_rd==rs), or
  - (i_exm_wr_en && i_exm_is_load && i_exm_rd==rs).
  - Result: a load-use pair incurs exactly 2 bubble cycles when EX never stalls.
- Advance condition: adv = !o_valid || i_ex_ready.
- o_ready = adv && !hazard.
- Capture: at posedge with adv=1:
  - o_valid <= i_valid && !hazard;
  - o_pc, operands and rd fields load from current inputs when i_valid && !hazard, otherwise they hold.
- When adv=0, all outputs hold. No upstream instruction is accepted.
- Flush: takes priority over capture; o_valid <= 0 and o_ready = 0 that cycle. Reset takes priority over flush.
- Latency: one cycle from an accepted input to o_valid.
- No combinational path from i_ex_ready to o_valid.

Test Plan:
- Reset: drive aresetn=0 for 2 cycles -> o_valid=0, all outputs 0, every register reads 0.
- WB write-through: write x5=0xDEAD_BEEF via WB while an instruction with rs1=5 is in ID -> o_rs1_data=0xDEADBEEF next cycle.
- Forwarding priority: EX/MEM x7=0x11, WB x7=0x22, RF x7=0x33, ID reads rs1=7 and rs2=7 -> both operands 0x11. Same case with rs=0 -> both operands 0.
- Load-use: load x3 accepted, next instruction uses x3 -> o_ready=0 for 2 cycles, o_valid=0 bubbles in those cycles, then the operand equals the WB-forwarded load data.
- Backpressure: o_valid=1, i_ex_ready=0 for 3 cycles -> outputs stable, o_ready=0. On release, the next instruction is captured in the following cycle.
- Flush during hazard stall: flush=1 -> o_valid=0 next cycle, upstream not accepted; with no further hazard, o_ready=1 once flush is deasserted.
